// File: rtl/ysyx_24110015_shift_register_if.sv
// Output bus of the latency LFSR: one byte of pseudo-random state, refreshed every clock.
// No handshake here. The master drives y from flops every cycle, and the slave may sample y on any edge.
interface ysyx_24110015_shift_register_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] y;

    modport master (output y);
    modport slave  (input  y);
endinterface

// File: rtl/ysyx_24110015_shift_register.sv
// Free-running 8-bit maximal-length LFSR (x^8+x^4+x^3+x^2+1), shifting right with feedback into the MSB.
// The memory model uses its state as the per-transaction access-latency count.
module ysyx_24110015_shift_register #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_24110015_shift_register_if.master bus
);

    logic [WIDTH-1:0] lfsr_q;
    logic             fb;

    always_comb begin
        fb = lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
    end

    // All-zero is a lock-up state for an XOR LFSR, so reseed instead of shifting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else if (lfsr_q == '0) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {fb, lfsr_q[WIDTH-1:1]};
        end
    end

    assign bus.y = lfsr_q;

endmodule

// File: tb/tb_ysyx_24110015_shift_register.sv
// Directed bench for the latency LFSR: reset, sequence, period, coverage, mid-run reset, reset glitch, zero recovery.
module tb_ysyx_24110015_shift_register;

    logic clk;
    logic rst;
    int   total_cnt;
    int   pass_cnt;

    logic [7:0] exp_seq [0:9];

    ysyx_24110015_shift_register_if #(.WIDTH(8)) bus ();

    ysyx_24110015_shift_register #(
        .WIDTH(8),
        .SEED (8'h01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (bus.y !== 8'h01)
                $display("FAIL reset_hold[%0d]: got %02h expected 01", i, bus.y);
            else
                pass_cnt++;
        end
        rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            total_cnt++;
            if (bus.y !== exp_seq[i])
                $display("FAIL seq_after_reset[%0d]: got %02h expected %02h", i, bus.y, exp_seq[i]);
            else
                pass_cnt++;
        end
    endtask

    // Period and coverage share one 255-edge run.
    task automatic test_period_coverage();
        int seen [0:255];
        int first_return;
        for (int v = 0; v < 256; v++) seen[v] = 0;
        first_return = 0;
        do_reset();
        for (int i = 1; i <= 255; i++) begin
            step();
            seen[bus.y]++;
            if (bus.y === 8'h01 && first_return == 0) first_return = i;
        end
        total_cnt++;
        if (first_return != 255)
            $display("FAIL period: first return to 01 at edge %0d expected 255", first_return);
        else
            pass_cnt++;
        total_cnt++;
        if (seen[0] != 0)
            $display("FAIL zero_never: 00 seen %0d times expected 0", seen[0]);
        else
            pass_cnt++;
        for (int v = 1; v < 256; v++) begin
            total_cnt++;
            if (seen[v] != 1)
                $display("FAIL coverage[%02h]: seen %0d times expected 1", v, seen[v]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 37; i++) step();
        rst = 1'b0;
        step();
        total_cnt++;
        if (bus.y !== 8'h01)
            $display("FAIL mid_reset: got %02h expected 01", bus.y);
        else
            pass_cnt++;
        rst = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            total_cnt++;
            if (bus.y !== exp_seq[i])
                $display("FAIL mid_reset_seq[%0d]: got %02h expected %02h", i, bus.y, exp_seq[i]);
            else
                pass_cnt++;
        end
    endtask

    // A low pulse that starts and ends between edges must not be seen.
    task automatic test_sync_glitch();
        do_reset();
        step();
        total_cnt++;
        if (bus.y !== 8'h80)
            $display("FAIL glitch_pre: got %02h expected 80", bus.y);
        else
            pass_cnt++;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            step();
            total_cnt++;
            if (bus.y !== exp_seq[i])
                $display("FAIL glitch_seq[%0d]: got %02h expected %02h", i, bus.y, exp_seq[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_zero_recovery();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        force dut.lfsr_q = 8'h00;
        #1;
        release dut.lfsr_q;
        #1;
        total_cnt++;
        if (bus.y !== 8'h00)
            $display("FAIL zero_forced: got %02h expected 00", bus.y);
        else
            pass_cnt++;
        step();
        total_cnt++;
        if (bus.y !== 8'h01)
            $display("FAIL zero_recover: got %02h expected 01", bus.y);
        else
            pass_cnt++;
        step();
        total_cnt++;
        if (bus.y !== 8'h80)
            $display("FAIL zero_recover_next: got %02h expected 80", bus.y);
        else
            pass_cnt++;
    endtask

    initial begin
        exp_seq   = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4, 8'hE2, 8'h71, 8'h38};
        total_cnt = 0;
        pass_cnt  = 0;
        rst       = 1'b0;
        #1;
        test_reset();
        test_period_coverage();
        test_mid_reset();
        test_sync_glitch();
        test_zero_recovery();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
